// File: rtl/cavlc_coeff_scan.sv
// -----------------------------------------------------------------------------
// cavlc_coeff_scan
//   Sits after the 4x4 zigzag reorder in the H.264 CAVLC path. Takes one block
//   of 16 zigzag-ordered signed coefficients and walks it from position 15 down
//   to 0, one coefficient per cycle. The walk derives TotalCoeff, TrailingOnes
//   and TotalZeros and fills a level buffer. The nonzero levels are then
//   streamed out with their run_before values, highest scan position first.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  block handshake; in_ready is high only in IDLE
//   in_coeff           16 x DW coefficients, [i*DW +: DW] = scan position i
//   sum_valid          total_coeff / trailing_ones / total_zeros are valid
//   lvl_valid/ready    level stream handshake
//   lvl_value          signed level value
//   lvl_run            run_before for this level
//   lvl_is_t1          level is one of the trailing ones
//   lvl_last           lowest-position nonzero of the block
//   blk_done           one-cycle pulse at the end of each completed block
// -----------------------------------------------------------------------------
module cavlc_coeff_scan #(
    parameter int DW = 15,
    parameter int NC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NC*DW-1:0]     in_coeff,
    output logic                 sum_valid,
    output logic [4:0]           total_coeff,
    output logic [1:0]           trailing_ones,
    output logic [3:0]           total_zeros,
    output logic                 lvl_valid,
    input  logic                 lvl_ready,
    output logic signed [DW-1:0] lvl_value,
    output logic [3:0]           lvl_run,
    output logic                 lvl_is_t1,
    output logic                 lvl_last,
    output logic                 blk_done
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    localparam logic signed [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};
    localparam logic signed [DW-1:0] NEG_ONE = '1;

    state_t               state_q,   state_d;
    logic signed [DW-1:0] coef_q [NC];
    logic signed [DW-1:0] coef_d [NC];
    logic signed [DW-1:0] lv_q   [NC];   // level buffer: values
    logic signed [DW-1:0] lv_d   [NC];
    logic [3:0]           lp_q   [NC];   // level buffer: scan positions
    logic [3:0]           lp_d   [NC];
    logic [3:0]           idx_q,     idx_d;
    logic [3:0]           rd_ptr_q,  rd_ptr_d;
    logic [4:0]           tc_q,      tc_d;
    logic [1:0]           t1_q,      t1_d;
    logic [3:0]           tz_q,      tz_d;
    logic                 t1_open_q, t1_open_d;

    logic                 in_ready_q,  in_ready_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 blk_done_q,  blk_done_d;
    logic                 lvl_valid_q, lvl_valid_d;
    logic signed [DW-1:0] lvl_value_q, lvl_value_d;
    logic [3:0]           lvl_run_q,   lvl_run_d;
    logic                 lvl_is_t1_q, lvl_is_t1_d;
    logic                 lvl_last_q,  lvl_last_d;

    logic signed [DW-1:0] cur;
    logic                 cur_is_one;
    logic [3:0]           nxt_ptr;
    logic                 is_final;
    logic                 emit_d;

    always_comb begin
        state_d   = state_q;
        coef_d    = coef_q;
        lv_d      = lv_q;
        lp_d      = lp_q;
        idx_d     = idx_q;
        rd_ptr_d  = rd_ptr_q;
        tc_d      = tc_q;
        t1_d      = t1_q;
        tz_d      = tz_q;
        t1_open_d = t1_open_q;

        cur        = coef_q[idx_q];
        cur_is_one = (cur == ONE) || (cur == NEG_ONE);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < NC; i++) begin
                        coef_d[i] = in_coeff[i*DW +: DW];
                    end
                    idx_d     = 4'd15;
                    rd_ptr_d  = 4'd0;
                    tc_d      = 5'd0;
                    t1_d      = 2'd0;
                    tz_d      = 4'd0;
                    t1_open_d = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (cur != '0) begin
                    // The running nonzero count doubles as the buffer write pointer.
                    lv_d[tc_q[3:0]] = cur;
                    lp_d[tc_q[3:0]] = idx_q;
                    tc_d            = tc_q + 5'd1;
                    if (t1_open_q && cur_is_one && (t1_q != 2'd3)) begin
                        t1_d = t1_q + 2'd1;
                    end else begin
                        t1_open_d = 1'b0;
                    end
                end else if (tc_q != 5'd0) begin
                    // Only zeros below the highest nonzero count toward TotalZeros.
                    tz_d = tz_q + 4'd1;
                end
                idx_d = idx_q - 4'd1;
                if (idx_q == 4'd0) begin
                    state_d = (tc_d != 5'd0) ? EMIT : DONE;
                end
            end
            EMIT: begin
                if (lvl_ready) begin
                    if ({1'b0, rd_ptr_q} == tc_q - 5'd1) begin
                        state_d = DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 4'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are formed from the next-cycle view
        // of the buffer and read pointer; this also covers a level written on
        // the very last SCAN cycle.
        emit_d      = (state_d == EMIT);
        nxt_ptr     = rd_ptr_d + 4'd1;
        is_final    = ({1'b0, rd_ptr_d} == tc_d - 5'd1);
        in_ready_d  = (state_d == IDLE);
        sum_valid_d = (state_d == EMIT) || (state_d == DONE);
        blk_done_d  = (state_d == DONE);
        lvl_valid_d = emit_d;
        lvl_value_d = emit_d ? lv_d[rd_ptr_d] : '0;
        lvl_run_d   = '0;
        if (emit_d) begin
            // The lowest nonzero's run is every position beneath it.
            lvl_run_d = is_final ? lp_d[rd_ptr_d]
                                 : lp_d[rd_ptr_d] - lp_d[nxt_ptr] - 4'd1;
        end
        lvl_is_t1_d = emit_d && (rd_ptr_d < {2'b00, t1_d});
        lvl_last_d  = emit_d && is_final;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < NC; i++) begin
                coef_q[i] <= '0;
                lv_q[i]   <= '0;
                lp_q[i]   <= '0;
            end
            idx_q       <= '0;
            rd_ptr_q    <= '0;
            tc_q        <= '0;
            t1_q        <= '0;
            tz_q        <= '0;
            t1_open_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
            blk_done_q  <= 1'b0;
            lvl_valid_q <= 1'b0;
            lvl_value_q <= '0;
            lvl_run_q   <= '0;
            lvl_is_t1_q <= 1'b0;
            lvl_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            lv_q        <= lv_d;
            lp_q        <= lp_d;
            idx_q       <= idx_d;
            rd_ptr_q    <= rd_ptr_d;
            tc_q        <= tc_d;
            t1_q        <= t1_d;
            tz_q        <= tz_d;
            t1_open_q   <= t1_open_d;
            in_ready_q  <= in_ready_d;
            sum_valid_q <= sum_valid_d;
            blk_done_q  <= blk_done_d;
            lvl_valid_q <= lvl_valid_d;
            lvl_value_q <= lvl_value_d;
            lvl_run_q   <= lvl_run_d;
            lvl_is_t1_q <= lvl_is_t1_d;
            lvl_last_q  <= lvl_last_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign sum_valid     = sum_valid_q;
    assign total_coeff   = tc_q;
    assign trailing_ones = t1_q;
    assign total_zeros   = tz_q;
    assign blk_done      = blk_done_q;
    assign lvl_valid     = lvl_valid_q;
    assign lvl_value     = lvl_value_q;
    assign lvl_run       = lvl_run_q;
    assign lvl_is_t1     = lvl_is_t1_q;
    assign lvl_last      = lvl_last_q;

endmodule
